// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, PC step and the fetch entry layout.
package core_pkg;
  localparam int ILEN   = 32;
  localparam int PC_INC = 4;
  localparam int PC_W   = 32;

  // One buffered fetch: the instruction word together with the PC it came from.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bus bundle of the prefetcher: redirect input, memory request/response port
// and the instruction port toward the fetch unit.
interface ifetch_prefetch_if
  import core_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [ILEN-1:0] mem_resp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  // Prefetcher side.
  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  instr_ready,
    output mem_req_valid, mem_req_addr,
    output instr_valid, instr, instr_pc
  );

  // Core / memory side.
  modport slave (
    output redirect_valid, redirect_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output instr_ready,
    input  mem_req_valid, mem_req_addr,
    input  instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Small in-order FIFO with push/pop/flush and an occupancy count.
// Pushing into a full FIFO is the caller's problem; the prefetcher's credit
// scheme guarantees it never happens.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;

  // Storage array: data only, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch buffer. Issues sequential word fetches as long as every
// live in-flight request has a guaranteed FIFO slot, buffers {pc, instr} in
// order, and on redirect flushes the FIFO and counts the in-flight responses
// that must be thrown away.
module ifetch_prefetch
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  ifetch_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   fifo_din, fifo_dout;
  logic [CW:0]     used;
  logic [XLEN-1:0] redir_tgt;
  logic            redir, req_valid, accept, resp, push, pop, head_valid;

  assign redir     = bus.redirect_valid;
  assign resp      = bus.mem_resp_valid;
  assign redir_tgt = bus.redirect_pc & ~XLEN'(3);

  // Slots already promised: buffered entries plus live (non-stale) requests.
  assign used      = {1'b0, fifo_cnt} + {1'b0, outstanding_q} - {1'b0, drop_q};
  assign req_valid = !reset && !redir && (used < (CW+1)'(DEPTH));
  assign accept    = req_valid && bus.mem_req_ready;

  assign head_valid = (fifo_cnt != '0);
  assign push       = resp && !redir && (drop_q == '0);
  assign pop        = head_valid && bus.instr_ready && !redir;
  assign fifo_din   = {resp_pc_q, bus.mem_resp_data};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redir),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  // Next-state for fetch/response PCs and the in-flight/drop counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
    drop_d        = drop_q;
    if (redir) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = redir_tgt;
      resp_pc_d  = redir_tgt;
      drop_d     = outstanding_q - CW'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
      if (resp) begin
        if (drop_q != '0) drop_d    = drop_q - CW'(1);
        else              resp_pc_d = resp_pc_q + XLEN'(PC_INC);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.instr_valid   = head_valid;
  // Head fields forced to zero when empty so reset clears them immediately.
  assign bus.instr         = head_valid ? fifo_dout[ILEN-1:0]  : '0;
  assign bus.instr_pc      = head_valid ? fifo_dout[EW-1:ILEN] : '0;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: a latency-programmable memory plus an epoch-tagged
// reference model of the delivered instruction stream.
module tb_ifetch_prefetch;
  import core_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_prefetch_if #(.XLEN(32)) bus ();

  ifetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t        pend[$];  // requests accepted by memory, in order
  fetch_entry_t mq[$];    // instructions the fetch unit should see, in order
  int           cyc, epoch, lat, checks, failures, pops;
  logic [31:0]  exp_fetch;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9617;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) n++;
    return n;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit mrdy);
    bit           resp_now, acc, pop, exp_rv;
    mreq_t        r;
    fetch_entry_t e;
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    bus.mem_req_ready  = mrdy;
    resp_now = (pend.size() != 0) && (pend[0].due <= cyc);
    bus.mem_resp_valid = resp_now;
    bus.mem_resp_data  = resp_now ? memw(pend[0].addr) : 32'h0;
    #1;
    exp_rv = !redir && ((mq.size() + live_cnt()) < DEPTH);
    chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.mem_req_addr, exp_fetch);
    chk("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr_pc", bus.instr_pc, mq[0].pc);
      chk("instr", bus.instr, mq[0].instr);
    end
    acc = exp_rv && mrdy;
    pop = (mq.size() != 0) && rdy && !redir;
    if (pop) begin
      void'(mq.pop_front());
      pops++;
    end
    if (resp_now) begin
      r = pend.pop_front();
      if (!redir && r.ep == epoch) begin
        e.pc    = r.addr;
        e.instr = memw(r.addr);
        mq.push_back(e);
      end
    end
    if (redir) begin
      mq.delete();
      epoch++;
      exp_fetch = {rpc[31:2], 2'b00};
    end else if (acc) begin
      r.addr = exp_fetch;
      r.due  = cyc + lat;
      r.ep   = epoch;
      pend.push_back(r);
      exp_fetch += 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  // Reset held for n cycles; memory is reset with the core.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    repeat (n) @(posedge clk);
    pend.delete();
    mq.delete();
    epoch++;
    exp_fetch = RESET_PC;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit          rd, rq, rr;
    logic [31:0] rpc;
    checks = 0; failures = 0; pops = 0; cyc = 0; epoch = 0; lat = 1;
    exp_fetch = RESET_PC;
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.mem_req_ready  = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    bus.instr_ready    = 1'b0;
    do_reset(2);

    // Streaming with 1-cycle memory: one instruction per cycle after fill.
    lat = 1;
    repeat (10) step(0, 0, 1, 1);
    pops = 0;
    repeat (20) step(0, 0, 1, 1);
    chk("throughput", pops, 20);

    // Fetch unit stalls: FIFO fills, requests stop, then drain without loss.
    repeat (10) step(0, 0, 0, 1);
    #1;
    chk("stall_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("stall_instr_valid", 32'(bus.instr_valid), 32'h1);
    repeat (10) step(0, 0, 1, 1);

    // 3-cycle memory, redirect with requests in flight.
    lat = 3;
    repeat (8) step(0, 0, 1, 1);
    step(1, 32'h100, 1, 1);
    #1;
    chk("drop_after_redirect", 32'(dut.drop_q), stale_cnt());
    repeat (15) step(0, 0, 1, 1);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    repeat (6) step(0, 0, 1, 1);
    step(1, 32'h40, 1, 1);
    #1;
    chk("flush_empty", 32'(bus.instr_valid), 32'h0);
    chk("flush_drop", 32'(dut.drop_q), stale_cnt());
    repeat (6) step(0, 0, 1, 1);

    // Unaligned redirect target is word-aligned.
    step(1, 32'h203, 1, 1);
    #1;
    chk("align", bus.mem_req_addr, 32'h200);
    repeat (8) step(0, 0, 1, 1);

    // Fetch across the top of the address space.
    step(1, 32'hFFFF_FFF4, 1, 1);
    repeat (12) step(0, 0, 1, 1);

    // Randomized traffic: varying latency, readies and redirects.
    for (int blk = 0; blk < 8; blk++) begin
      lat = $urandom_range(1, 5);
      for (int i = 0; i < 50; i++) begin
        rr  = ($urandom_range(0, 99) < 4);
        rd  = ($urandom_range(0, 99) < 70);
        rq  = ($urandom_range(0, 99) < 80);
        rpc = $urandom;
        step(rr, rpc, rd, rq);
      end
    end

    // Reset mid-stream with the FIFO full.
    lat = 2;
    repeat (12) step(0, 0, 0, 1);
    do_reset(3);
    step(0, 0, 1, 1);
    repeat (10) step(0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
